// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Purpose  : Byte FIFO in front of a UART transmitter. Bytes pushed on i_wr
//            are stored in a circular buffer and handed to the transmitter
//            one at a time using a write/busy handshake.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   i_clk       : system clock, all logic on the rising edge
//   i_reset_n   : synchronous active-low reset
//   i_wr        : push i_wr_data this cycle
//   i_wr_data   : byte to enqueue
//   o_full      : FIFO holds 2^DEPTH_LOG2 entries
//   o_empty     : FIFO holds no entries
//   o_count     : current occupancy
//   o_overflow  : sticky, a push was dropped while full
//   o_tx_write  : byte offer to the transmitter
//   o_tx_data   : byte offered, stable while o_tx_write=1
//   i_tx_busy   : transmitter busy (frame in progress)
// ============================================================================
module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_wr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic                  o_overflow,
  output logic                  o_tx_write,
  output logic [DATA_WIDTH-1:0] o_tx_data,
  input  logic                  i_tx_busy
);

  localparam int                  c_DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] c_CNT_FULL  = (DEPTH_LOG2+1)'(c_DEPTH);
  localparam logic [DEPTH_LOG2:0] c_CNT_ONE   = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2:0] c_CNT_ZERO  = '0;
  localparam logic [DEPTH_LOG2-1:0] c_PTR_ONE = (DEPTH_LOG2)'(1);

  typedef enum logic [1:0] {
    D_IDLE  = 2'd0,
    D_OFFER = 2'd1,
    D_WAIT  = 2'd2
  } drain_state_t;

  logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_full;
  logic                  r_empty;
  logic                  r_overflow;
  logic                  r_tx_write;
  logic [DATA_WIDTH-1:0] r_tx_data;
  drain_state_t          r_state;

  logic                  w_push;
  logic                  w_pop;
  logic [DEPTH_LOG2:0]   w_count_next;

  // Full is judged from the registered state, so a push on a pop edge while
  // full is still dropped.
  assign w_push = i_wr & ~r_full;
  // The transmitter has taken the byte once it reports busy during an offer.
  assign w_pop  = (r_state == D_OFFER) & i_tx_busy;

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + c_CNT_ONE;
      2'b01:   w_count_next = r_count - c_CNT_ONE;
      default: w_count_next = r_count;
    endcase
  end

  // Storage is not reset; pointers and count define which entries are valid.
  always_ff @(posedge i_clk) begin
    if (i_reset_n && w_push) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
      r_tx_write <= 1'b0;
      r_tx_data  <= '0;
      r_state    <= D_IDLE;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (i_wr && r_full) begin
        r_overflow <= 1'b1;
      end
      r_count <= w_count_next;
      r_full  <= (w_count_next == c_CNT_FULL);
      r_empty <= (w_count_next == c_CNT_ZERO);

      case (r_state)
        D_IDLE: begin
          if (!r_empty && !i_tx_busy) begin
            r_tx_data  <= r_mem[r_rd_ptr];
            r_tx_write <= 1'b1;
            r_state    <= D_OFFER;
          end
        end
        D_OFFER: begin
          // No timeout: the transmitter samples write on its own bit clock.
          if (i_tx_busy) begin
            r_tx_write <= 1'b0;
            r_rd_ptr   <= r_rd_ptr + c_PTR_ONE;
            r_state    <= D_WAIT;
          end
        end
        D_WAIT: begin
          if (!i_tx_busy) begin
            r_state <= D_IDLE;
          end
        end
        default: begin
          r_tx_write <= 1'b0;
          r_state    <= D_IDLE;
        end
      endcase
    end
  end

  assign o_full     = r_full;
  assign o_empty    = r_empty;
  assign o_count    = r_count;
  assign o_overflow = r_overflow;
  assign o_tx_write = r_tx_write;
  assign o_tx_data  = r_tx_data;

endmodule
`default_nettype wire

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 The module SHALL have parameter DEPTH_LOG2, default 4, meaning log2 of FIFO depth (16 entries).
REQ-002 The module SHALL have parameter DATA_WIDTH, default 8, meaning byte width passed to the UART transmitter.
REQ-003 The module SHALL have port i_clk, input, 1, meaning the single system clock; all logic on its rising edge.
REQ-004 The module SHALL have port i_reset_n, input, 1, meaning reset, synchronous and active-low.
REQ-005 The module SHALL have port i_wr, input, 1, meaning push i_wr_data this cycle.
REQ-006 The module SHALL have port i_wr_data, input, DATA_WIDTH, meaning byte to enqueue.
REQ-007 The module SHALL have port o_full, output, 1, meaning count == 2^DEPTH_LOG2.
REQ-008 The module SHALL have port o_empty, output, 1, meaning count == 0.
REQ-009 The module SHALL have port o_count, output, DEPTH_LOG2+1, meaning current occupancy.
REQ-010 The module SHALL have port o_overflow, output, 1, meaning sticky flag: a push was dropped while full.
REQ-011 The module SHALL have port o_tx_write, output, 1, meaning byte offer to the downstream transmitter's write input.
REQ-012 The module SHALL have port o_tx_data, output, DATA_WIDTH, meaning byte offered; stable while o_tx_write=1.
REQ-013 The module SHALL have port i_tx_busy, input, 1, meaning the transmitter's busy output (high while a frame is in progress).

Function
REQ-014 Storage SHALL be a circular buffer with DEPTH_LOG2-bit read/write pointers wrapping modulo depth; count SHALL be held separately at DEPTH_LOG2+1 bits.
REQ-015 Push: i_wr=1 and not full -> write mem[wr_ptr], wr_ptr+1, count+1 at the next edge.
REQ-016 Push while full SHALL be dropped (no pointer/count change) and SHALL set o_overflow=1 until reset.
REQ-017 o_full, o_empty, o_count SHALL be registered and reflect the state after the current edge.
REQ-018 Drain FSM states: D_IDLE, D_OFFER, D_WAIT.
REQ-019 D_IDLE: if !o_empty and !i_tx_busy -> D_OFFER; latch mem[rd_ptr] into o_tx_data and set o_tx_write=1 at that edge.
REQ-020 D_OFFER: hold o_tx_write=1 and o_tx_data unchanged until i_tx_busy=1 is sampled; then -> D_WAIT, o_tx_write=0, rd_ptr+1, count-1 (pop) at that edge.
REQ-021 D_OFFER SHALL wait indefinitely for busy (transmitter samples write on its slower bit clock); no timeout.
REQ-022 D_WAIT: on i_tx_busy=0 sampled -> D_IDLE; next byte may be offered no earlier than the following cycle.
REQ-023 Simultaneous push (not full) and pop SHALL leave count unchanged and both pointers advance; push when full on a pop cycle is still dropped (full evaluated from registered state).
REQ-024 Latency: push into empty FIFO at edge N -> o_tx_write=1 after edge N+1 (earliest), given i_tx_busy=0.
REQ-025 Pushes SHALL NOT alter o_tx_data while in D_OFFER; bytes SHALL leave in push order with no loss or duplication.
REQ-026 If i_tx_busy=1 while in D_IDLE, the FSM SHALL stay in D_IDLE.

Reset
REQ-027 While i_reset_n=0 at an edge: pointers=0, count=0, FSM=D_IDLE, o_tx_write=0, o_tx_data=0, o_empty=1, o_full=0, o_count=0, o_overflow=0.
REQ-028 Reset mid-offer or mid-frame SHALL discard all queued bytes and the pending offer; memory contents need not be cleared.
REQ-029 Reset SHALL dominate i_wr in the same cycle.

Verification
REQ-030 Single byte: reset, push 0x48, busy model rises 3 cycles after write and stays 10 cycles -> o_tx_write high 1 cycle after push, drops when busy seen, o_tx_data=0x48, o_empty=1 after pop.
REQ-031 Order: push "Hello" (0x48,0x65,0x6C,0x6C,0x6F) back-to-back -> transmitter model receives same 5 bytes in order, o_count peaks at 5 (or 4 if a pop overlaps).
REQ-032 Full/overflow: busy held 1, push 17 bytes 0x00..0x10 -> o_full=1 after 16th, 0x10 dropped, o_overflow=1; release busy -> 0x00..0x0F emitted.
REQ-033 Wrap: 40 pushes interleaved with drains -> pointers wrap twice, output sequence matches input, count never exceeds 16.
REQ-034 Simultaneous: push on the exact pop edge with count=16 -> push dropped and o_overflow=1; with count=5 -> count stays 5.
REQ-035 Reset mid-operation: assert i_reset_n=0 during D_OFFER with 3 queued -> next cycle o_tx_write=0, o_count=0, o_empty=1, no byte emitted afterwards.
